// File: rtl/pl_dmem_pkg.sv
// pl_dmem_pkg -- shared types and constants for the MEM-stage data RAM arbiter.
//   arb_state_e : arbiter state (S_CPU normal CPU priority, S_FORCE one forced DMA slot)
//   mem_req_t   : one requester's view of a RAM access (write enable, byte address, data)
//   DATA_W      : data/address bus width
//   WAIT_W      : width of the DMA starvation wait counter
package pl_dmem_pkg;

  localparam int DATA_W = 32;
  localparam int WAIT_W = 4;

  typedef enum logic {
    S_CPU   = 1'b0,
    S_FORCE = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;

endpackage

// File: rtl/pl_dmem_starve_ctr.sv
// pl_dmem_starve_ctr -- saturating count of consecutive cycles the DMA port was
// requesting but not granted. Clears on any cycle the DMA is not blocked.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset
//   blocked_i : DMA requesting and not granted this cycle
//   hit_o     : counter currently equals MAX_WAIT-1 (one more blocked cycle
//               reaches the bound)
module pl_dmem_starve_ctr
  import pl_dmem_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic blocked_i,
  output logic hit_o
);

  localparam logic [WAIT_W-1:0] HIT_VAL = WAIT_W'(MAX_WAIT - 1);
  localparam logic [WAIT_W-1:0] SAT_VAL = '1;

  logic [WAIT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (blocked_i) cnt_d = (cnt_q == SAT_VAL) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign hit_o = (cnt_q == HIT_VAL);

endmodule

// File: rtl/pl_dmem_arbiter.sv
// pl_dmem_arbiter -- shares the single-port data RAM between the CPU MEM stage
// (priority) and a DMA/debug loader port, one RAM access per cycle.
//
// Build option: PL_DMEM_ARB_STARVE_EN
//   defined   : bounded-wait guard; after MAX_WAIT consecutive blocked DMA
//               cycles the next cycle is a forced DMA slot and the CPU stalls.
//   undefined : strict CPU priority, c_stall tied low, MAX_WAIT unused.
//
// Ports:
//   clock, reset           : clock, synchronous active-high reset
//   c_req/c_we/c_addr/c_wdata, c_rdata, c_stall : CPU MEM-stage access
//   d_req/d_we/d_addr/d_wdata, d_gnt, d_rvalid, d_rdata : DMA access
//   ram_we/ram_addr/ram_wdata, ram_rdata : RAM side (RAM on inverted clock,
//                                           read data valid same cycle)
module pl_dmem_arbiter
  import pl_dmem_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [DATA_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic [DATA_W-1:0] c_rdata,
  output logic              c_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  mem_req_t cpu_r, dma_r, own_r;
  logic     force_slot;
  logic     cpu_own, dma_own;
  logic              d_rvalid_q;
  logic [DATA_W-1:0] d_rdata_q;

  assign cpu_r = '{we: c_we, addr: c_addr, wdata: c_wdata};
  assign dma_r = '{we: d_we, addr: d_addr, wdata: d_wdata};

  // Grant: a forced slot only matters while the DMA is actually requesting;
  // otherwise behave as plain CPU priority.
  always_comb begin
    cpu_own = 1'b0;
    dma_own = 1'b0;
    if (force_slot && d_req) dma_own = 1'b1;
    else if (c_req)          cpu_own = 1'b1;
    else if (d_req)          dma_own = 1'b1;
  end

  assign d_gnt   = dma_own;
  assign c_stall = force_slot & d_req & c_req;

  // With no owner the CPU values stay on the bus so an idle RAM read still
  // tracks the MEM stage; only the write enable is suppressed.
  always_comb begin
    own_r = cpu_r;
    if (dma_own) own_r = dma_r;
    if (!cpu_own && !dma_own) own_r.we = 1'b0;
  end

  assign ram_we    = own_r.we;
  assign ram_addr  = own_r.addr[ADDR_W+1:2];
  assign ram_wdata = own_r.wdata;
  assign c_rdata   = ram_rdata;

`ifdef PL_DMEM_ARB_STARVE_EN
  arb_state_e state_q, state_d;
  logic       hit;
  logic       blocked;

  assign blocked    = d_req & ~dma_own;
  assign force_slot = (state_q == S_FORCE);

  pl_dmem_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_ctr (
    .clk_i     (clock),
    .rst_i     (reset),
    .blocked_i (blocked),
    .hit_o     (hit)
  );

  // A forced slot lasts exactly one cycle whether or not the DMA used it.
  always_comb begin
    state_d = S_CPU;
    if (state_q == S_CPU && hit && blocked) state_d = S_FORCE;
  end

  always_ff @(posedge clock) begin
    if (reset) state_q <= S_CPU;
    else       state_q <= state_d;
  end
`else
  localparam int UNUSED_MAX_WAIT = MAX_WAIT;
  assign force_slot = 1'b0;
`endif

  // DMA read data is captured at the end of the grant cycle and held.
  always_ff @(posedge clock) begin
    if (reset) begin
      d_rvalid_q <= 1'b0;
      d_rdata_q  <= '0;
    end else begin
      d_rvalid_q <= dma_own & ~d_we;
      if (dma_own && !d_we) d_rdata_q <= ram_rdata;
    end
  end

  assign d_rvalid = d_rvalid_q;
  assign d_rdata  = d_rdata_q;

  // Byte offset and high address bits are deliberately ignored (wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{c_addr[DATA_W-1:ADDR_W+2], c_addr[1:0],
                              d_addr[DATA_W-1:ADDR_W+2], d_addr[1:0]};

endmodule

// File: doc/pl_dmem_arbiter.md
# pl_dmem_arbiter

Arbiter for the single-port data RAM used by the pipeline's MEM stage. It shares the RAM between the CPU MEM stage and a DMA/debug loader port, with one RAM access per cycle. The CPU has priority. A bounded-wait starvation guard forces a DMA slot and stalls the pipeline for that cycle. The block sits between the MEM stage, the DMA port and the `pl_datamem` instance.

## Interface
Parameters:
- `ADDR_W`, 5 — RAM word-address width (2^ADDR_W words).
- `MAX_WAIT`, 4 — consecutive DMA-blocked cycles before a forced DMA slot (1..15).

Ports:
- `clock`  in  1  — system clock; the RAM is clocked separately by `mem_clock` (inverted `clock`).
- `reset`  in  1  — synchronous, active-high.
- `c_req`  in  1  — MEM stage holds a load or store.
- `c_we`  in  1  — CPU store.
- `c_addr`  in  32  — CPU byte address (ALU result).
- `c_wdata`  in  32  — CPU store data.
- `c_rdata`  out  32  — CPU load data.
- `c_stall`  out  1  — freeze PC, IF/ID, ID/EXE and EXE/MEM this cycle.
- `d_req`  in  1  — DMA request.
- `d_we`  in  1  — DMA write.
- `d_addr`  in  32  — DMA byte address.
- `d_wdata`  in  32  — DMA write data.
- `d_gnt`  out  1  — DMA access performed this cycle.
- `d_rvalid`  out  1  — `d_rdata` valid; one-cycle pulse.
- `d_rdata`  out  32  — DMA read data (registered).
- `ram_we`  out  1  — RAM write enable.
- `ram_addr`  out  ADDR_W  — RAM word address.
- `ram_wdata`  out  32  — RAM write data.
- `ram_rdata`  in  32  — RAM read data, valid within the same `clock` cycle.

## Operation
- **Grant decision:** combinational, from `state`, `c_req` and `d_req`.
- **State S_CPU (reset state):**
  - `c_req`=1 → CPU owns the RAM; `d_gnt`=0.
  - `c_req`=0 and `d_req`=1 → DMA owns the RAM; `d_gnt`=1; `c_stall`=0.
- **State S_FORCE:**
  - `d_req`=1 → DMA owns the RAM; `d_gnt`=1; `c_stall`=`c_req`.
  - `d_req`=0 → treated exactly as S_CPU.
- **Transitions:**
  - S_CPU → S_FORCE when `wait_cnt` == MAX_WAIT−1 and the DMA is blocked this cycle.
  - S_FORCE → S_CPU unconditionally after one cycle.
- **wait_cnt (4 bit):**
  - Increments on each cycle where `d_req`=1 and `d_gnt`=0.
  - Clears on `d_gnt` or when `d_req`=0.
  - Saturates at 15.
- **RAM drive:**
  - Owner's `we` → `ram_we`; owner's `addr[ADDR_W+1:2]` → `ram_addr`; owner's `wdata` → `ram_wdata`.
  - No owner → `ram_we`=0; `ram_addr`/`ram_wdata` = CPU values.
- **Addressing:** `addr[1:0]` and `addr[31:ADDR_W+2]` are ignored; addresses wrap modulo the RAM size.
- **CPU read data:** `c_rdata` = `ram_rdata`, passed through combinationally.
- **DMA read data:** on a granted DMA read, `d_rdata` <= `ram_rdata` and `d_rvalid` <= 1 at the next edge. Otherwise `d_rvalid` <= 0; `d_rdata` holds its value.
- **Simultaneous requests:**
  - Same address, CPU wins → the DMA retries later and sees the CPU's write.
  - Forced slot → the stalled CPU access replays the next cycle and sees the DMA write.
- **Reset:** `state`=S_CPU, `wait_cnt`=0, `d_rvalid`=0, `d_rdata`=0. Reset overrides everything: a forced slot pending at reset is dropped, and `d_rvalid` is 0 after the reset edge.

## Timing
- CPU access: zero added latency; data in the same cycle as the MEM stage.
- DMA read: grant in cycle N; `d_rdata` valid in cycle N+1.
- DMA write: completes at the `mem_clock` rising edge of the grant cycle.
- DMA requester protocol:
  - Hold `d_req`/`d_we`/`d_addr`/`d_wdata` stable until a cycle with `d_gnt`=1.
  - Only one access is consumed per granted cycle.
- Worst-case DMA wait with `c_req` stuck at 1: MAX_WAIT cycles, then a grant.
- `c_stall` is combinational and asserts at most one cycle in every MAX_WAIT+1.

## Configuration
- **`PL_DMEM_ARB_STARVE_EN` defined:** starvation guard, `wait_cnt` and S_FORCE are present, as described above.
- **Undefined:**
  - Strict CPU priority; `c_stall` is tied 0.
  - No S_FORCE state and no `wait_cnt`.
  - A DMA request is served only in cycles where `c_req`=0.
  - MAX_WAIT is unused.

## Structure
- Shared package `pl_dmem_pkg`:
  - state enum `{S_CPU, S_FORCE}`.
  - `DATA_W`=32.
  - `WAIT_W`=4.
- Sub-module `pl_dmem_starve_ctr`: the saturating wait counter, with a "threshold hit" output. Instantiated only under `PL_DMEM_ARB_STARVE_EN`.

## Test plan
- **Reset:** reset for 2 cycles with `d_req`=1 and `c_req`=1 → `d_gnt`=0, `d_rvalid`=0, `c_stall`=0, `d_rdata`=0.
- **DMA write then CPU read:** `c_req`=0; DMA writes 0xDEADBEEF to addr 0x8; next cycle CPU reads 0x8 → `c_rdata`=0xDEADBEEF, `c_stall`=0.
- **Starvation, macro on, MAX_WAIT=4:** `c_req`=1 constant, `d_req`=1 from cycle 0 → `d_gnt` and `c_stall` high in cycle 4 only; `d_rvalid` in cycle 5.
- **Macro off:** same stimulus → `d_gnt` never asserts. Drop `c_req` in cycle 10 → `d_gnt`=1 in cycle 10.
- **Address wrap:** DMA write 0x55 to addr 0x80 with ADDR_W=5 → CPU read of addr 0x0 returns 0x55.
- **Reset mid-operation:** reset asserted in a forced-slot cycle → `d_rvalid`=0 and state S_CPU after the edge; DMA is re-granted only after MAX_WAIT fresh blocked cycles.
